// File: rtl/i2c_pkg.sv
// I2C master engine shared definitions: command codes, phase states and
// the fixed SCL level of every phase.
package i2c_pkg;

   localparam logic [2:0] CMD_START = 3'd1;
   localparam logic [2:0] CMD_STOP  = 3'd2;
   localparam logic [2:0] CMD_WRITE = 3'd3;
   localparam logic [2:0] CMD_READ  = 3'd4;

   typedef enum logic [3:0] {
      IDLE,
      RS_LOW,
      START_SETUP,
      START_HOLD,
      BIT_LOW,
      BIT_HIGH,
      ACK_LOW,
      ACK_HIGH,
      STOP_LOW,
      STOP_SETUP,
      HELD
   } state_t;

   // SCL is released (1) in the setup/high phases and in IDLE.
   function automatic logic scl_level(input state_t s);
      case (s)
         IDLE, START_SETUP, START_HOLD, BIT_HIGH, ACK_HIGH, STOP_SETUP: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Only IDLE and HELD are untimed resting states.
   function automatic logic is_timed(input state_t s);
      return !(s == IDLE || s == HELD);
   endfunction

   function automatic logic cmd_known(input logic [2:0] c);
      return (c == CMD_START) || (c == CMD_STOP) || (c == CMD_WRITE) || (c == CMD_READ);
   endfunction

endpackage

// File: rtl/i2c_master_engine_phase_timer.sv
// Phase timer: captures the divisor at command acceptance and counts each
// phase from 0 to divisor, strobing phase_done on the last cycle.
// Optional clock stretching is enabled by defining I2C_CLOCK_STRETCH_EN.
module i2c_phase_timer #(
   parameter int CTR_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [CTR_WIDTH-1:0] divisor,
   input  logic                 run,
   input  logic                 scl_high,
   input  logic                 scl_in,
   output logic                 phase_done
);

   logic [CTR_WIDTH-1:0] count;
   logic [CTR_WIDTH-1:0] div_q;
   logic                 hold;
   logic                 at_end;

`ifdef I2C_CLOCK_STRETCH_EN
   // A slave holding SCL low freezes the count of a released-SCL phase.
   always_comb hold = scl_high && !scl_in;
`else
   logic unused_stretch;
   // SCL feedback is ignored when stretching is not built in.
   always_comb begin
      hold           = 1'b0;
      unused_stretch = scl_high ^ scl_in;
   end
`endif

   // Phase end detection and strobe.
   always_comb begin
      at_end     = (count == div_q);
      phase_done = run && !hold && at_end;
   end

   // Divisor capture and phase counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         div_q <= '0;
      end else begin
         if (load) div_q <= divisor;
         if (!run || hold || at_end) count <= '0;
         else                        count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_master_engine.sv
// I2C master byte engine: executes START/STOP/WRITE/READ commands as a
// sequence of timed bus phases and reports each completion with a pulse.
// Clock stretching support is built in when I2C_CLOCK_STRETCH_EN is defined.
module i2c_master_engine
   import i2c_pkg::*;
#(
   parameter int CTR_WIDTH  = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CTR_WIDTH-1:0]  dbl_clock_divisor,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic                  cmd_nack,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_ack,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  scl_out,
   output logic                  sda_out,
   input  logic                  scl_in,
   input  logic                  sda_in
);

   localparam int BW = $clog2(DATA_WIDTH + 1);

   state_t                state;
   state_t                state_nx;
   logic [2:0]            cmd_q;
   logic                  nack_q;
   logic [DATA_WIDTH-1:0] shreg;
   logic [BW-1:0]         bit_cnt;
   logic                  accept;
   logic                  cmd_err;
   logic                  last_bit;
   logic                  run;
   logic                  phase_done;

   i2c_phase_timer #(
      .CTR_WIDTH(CTR_WIDTH)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .divisor   (dbl_clock_divisor),
      .run       (run),
      .scl_high  (scl_level(state)),
      .scl_in    (scl_in),
      .phase_done(phase_done)
   );

   // Handshake decode: unknown codes and bus commands without a START are errors.
   always_comb begin
      accept   = cmd_valid && cmd_ready;
      cmd_err  = !cmd_known(cmd) || (state == IDLE && cmd != CMD_START);
      last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic: resting states branch on commands, timed states on phase_done.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept && !cmd_err) state_nx = START_SETUP;
         end
         HELD: begin
            if (accept && !cmd_err) begin
               case (cmd)
                  CMD_START: state_nx = RS_LOW;
                  CMD_STOP:  state_nx = STOP_LOW;
                  default:   state_nx = BIT_LOW;
               endcase
            end
         end
         RS_LOW:      if (phase_done) state_nx = START_SETUP;
         START_SETUP: if (phase_done) state_nx = START_HOLD;
         START_HOLD:  if (phase_done) state_nx = HELD;
         BIT_LOW:     if (phase_done) state_nx = BIT_HIGH;
         BIT_HIGH:    if (phase_done) state_nx = last_bit ? ACK_LOW : BIT_LOW;
         ACK_LOW:     if (phase_done) state_nx = ACK_HIGH;
         ACK_HIGH:    if (phase_done) state_nx = HELD;
         STOP_LOW:    if (phase_done) state_nx = STOP_SETUP;
         STOP_SETUP:  if (phase_done) state_nx = IDLE;
         default:     state_nx = IDLE;
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      cmd_ready = !is_timed(state);
      run       = is_timed(state);
      busy      = rsp_valid || run;
      scl_out   = scl_level(state);
      sda_out   = 1'b1;
      case (state)
         START_HOLD, HELD, STOP_LOW, STOP_SETUP: sda_out = 1'b0;
         BIT_LOW, BIT_HIGH: sda_out = (cmd_q == CMD_WRITE) ? shreg[DATA_WIDTH-1] : 1'b1;
         ACK_LOW, ACK_HIGH: sda_out = (cmd_q == CMD_READ) ? nack_q : 1'b1;
         default:           sda_out = 1'b1;
      endcase
   end

   // Command capture, bit shifting and completion reporting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_q     <= '0;
         nack_q    <= 1'b0;
         shreg     <= '0;
         bit_cnt   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_ack   <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         if (accept) begin
            cmd_q   <= cmd;
            nack_q  <= cmd_nack;
            shreg   <= cmd_data;
            bit_cnt <= '0;
            if (cmd_err) begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b1;
               rsp_ack   <= 1'b0;
               rsp_data  <= '0;
            end
         end
         if (phase_done) begin
            case (state)
               // Shifting on every bit serves both directions: WRITE moves the
               // next bit to the MSB, READ accumulates sda_in at the LSB.
               BIT_HIGH: begin
                  shreg   <= (shreg << 1) | DATA_WIDTH'(sda_in);
                  bit_cnt <= bit_cnt + 1'b1;
               end
               START_HOLD, STOP_SETUP: begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_ack   <= 1'b0;
                  rsp_data  <= '0;
               end
               ACK_HIGH: begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_ack   <= (cmd_q == CMD_READ) ? nack_q : sda_in;
                  rsp_data  <= (cmd_q == CMD_READ) ? shreg : '0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_engine.sv
// Self-checking bench for i2c_master_engine: a line-level reference model
// predicts bus waveforms and responses; a monitor scores every rsp_valid.
module tb_i2c_master_engine;

   localparam int CW = 16;
   localparam int W  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] dbl_clock_divisor = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd = '0;
   logic [W-1:0]  cmd_data = '0;
   logic          cmd_nack = 1'b0;
   logic          rsp_valid;
   logic [W-1:0]  rsp_data;
   logic          rsp_ack;
   logic          rsp_err;
   logic          busy;
   logic          scl_out;
   logic          sda_out;
   logic          scl_in;
   logic          sda_in = 1'b1;
   logic          stretch = 1'b0;

   assign scl_in = scl_out & ~stretch;

   i2c_master_engine #(
      .CTR_WIDTH (CW),
      .DATA_WIDTH(W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .dbl_clock_divisor(dbl_clock_divisor),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd              (cmd),
      .cmd_data         (cmd_data),
      .cmd_nack         (cmd_nack),
      .rsp_valid        (rsp_valid),
      .rsp_data         (rsp_data),
      .rsp_ack          (rsp_ack),
      .rsp_err          (rsp_err),
      .busy             (busy),
      .scl_out          (scl_out),
      .sda_out          (sda_out),
      .scl_in           (scl_in),
      .sda_in           (sda_in)
   );

   initial forever #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rsp_cnt = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   typedef struct {
      logic [W-1:0] data;
      logic         ack;
      logic         err;
      bit           chk_ack;
      bit           chk_data;
      int           acc;
      int           lat;
   } exp_t;

   exp_t       sb[$];
   exp_t       cur;
   logic [1:0] exp_trace[$];
   logic [1:0] exp_final;
   bit         held = 1'b0;

   // slave emulation controls
   int           slv_seq = 0;
   logic [2:0]   slv_kind = '0;
   logic [W-1:0] slv_byte = '0;
   logic         slv_ack = 1'b0;
   int           slv_sk = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_phase(input logic scl, input logic sda, input int n);
      repeat (n) exp_trace.push_back({scl, sda});
   endtask

   // Reference: per-command list of line levels, each phase div+1 cycles long.
   task automatic model(input logic [2:0] c, input logic [W-1:0] d, input logic n, input int dv,
                        input logic [W-1:0] sbyte, input logic sack, input int sk);
      int   p;
      int   extra;
      logic b;
      p = dv + 1;
      extra = 0;
`ifdef I2C_CLOCK_STRETCH_EN
      extra = 10;
`endif
      exp_trace.delete();
      cur.data = '0;
      cur.ack = 1'b0;
      cur.chk_ack = 1'b0;
      cur.chk_data = 1'b0;
      cur.err = (c < 3'd1 || c > 3'd4) || (!held && c != 3'd1);
      if (cur.err) begin
         exp_final = held ? 2'b00 : 2'b11;
      end else begin
         case (c)
            3'd1: begin
               if (held) add_phase(1'b0, 1'b1, p);
               add_phase(1'b1, 1'b1, p);
               add_phase(1'b1, 1'b0, p);
               exp_final = 2'b00;
               held = 1'b1;
            end
            3'd2: begin
               add_phase(1'b0, 1'b0, p);
               add_phase(1'b1, 1'b0, p);
               exp_final = 2'b11;
               held = 1'b0;
            end
            3'd3: begin
               for (int i = 0; i < W; i++) begin
                  b = d[W-1-i];
                  add_phase(1'b0, b, p);
                  add_phase(1'b1, b, p + ((i == sk) ? extra : 0));
               end
               add_phase(1'b0, 1'b1, p);
               add_phase(1'b1, 1'b1, p);
               cur.ack = sack;
               cur.chk_ack = 1'b1;
               exp_final = 2'b00;
            end
            default: begin
               for (int i = 0; i < W; i++) begin
                  add_phase(1'b0, 1'b1, p);
                  add_phase(1'b1, 1'b1, p + ((i == sk) ? extra : 0));
               end
               add_phase(1'b0, n, p);
               add_phase(1'b1, n, p);
               cur.ack = n;
               cur.data = sbyte;
               cur.chk_ack = 1'b1;
               cur.chk_data = 1'b1;
               exp_final = 2'b00;
            end
         endcase
      end
      cur.lat = exp_trace.size();
   endtask

   // Slave: presents read bits / ack on SCL rising edges, optional stretch.
   initial begin
      int   last = 0;
      int   rc = 0;
      int   left = 0;
      logic prev = 1'b1;
      forever begin
         @(negedge clk);
         if (left > 0) begin
            left--;
            if (left == 0) stretch = 1'b0;
         end
         if (slv_seq != last) begin
            last = slv_seq;
            rc = 0;
         end
         if (scl_out && !prev) begin
            if (rc == slv_sk) begin
               stretch = 1'b1;
               left = 10;
            end
            if (rc < W) sda_in = (slv_kind == 3'd4) ? slv_byte[W-1-rc] : 1'b1;
            else if (rc == W) sda_in = (slv_kind == 3'd3) ? slv_ack : 1'b1;
            rc++;
         end else if (!scl_out && prev) begin
            sda_in = 1'b1;
         end
         prev = scl_out;
      end
   end

   // Monitor: pops the expected response whenever the DUT completes.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rsp: rsp_valid=1 with no pending command");
            end else begin
               e = sb.pop_front();
               rsp_cnt++;
               check("rsp_err", rsp_err, e.err);
               check("rsp_latency", cyc - e.acc, e.lat);
               if (e.chk_ack) check("rsp_ack", rsp_ack, e.ack);
               if (e.chk_data) check("rsp_data", rsp_data, e.data);
            end
         end
      end
   end

   task automatic issue(input logic [2:0] c, input logic [W-1:0] d, input logic n, input int dv,
                        input logic [W-1:0] sbyte, input logic sack, input int sk, output bit ok);
      int k;
      model(c, d, n, dv, sbyte, sack, sk);
      slv_kind = c;
      slv_byte = sbyte;
      slv_ack = sack;
      slv_sk = sk;
      slv_seq++;
      @(negedge clk);
      cmd = c;
      cmd_data = d;
      cmd_nack = n;
      dbl_clock_divisor = CW'(dv);
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      ok = cmd_ready;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL cmd_accept: cmd_ready=0 expected 1 within 200 cycles");
         cmd_valid = 1'b0;
         return;
      end
      cur.acc = cyc + 1;
      sb.push_back(cur);
      @(negedge clk);
      // captured values must be unaffected by later input changes
      cmd_valid = 1'b0;
      cmd = 3'($urandom);
      cmd_data = W'($urandom);
      cmd_nack = 1'($urandom);
      dbl_clock_divisor = CW'($urandom_range(0, 7));
   endtask

   task automatic run_cmd(input logic [2:0] c, input logic [W-1:0] d, input logic n, input int dv,
                          input logic [W-1:0] sbyte, input logic sack, input int sk, input string tag);
      bit         ok;
      int         k;
      int         bad_i;
      logic [1:0] got;
      logic [1:0] bad_got;
      logic [1:0] bad_exp;
      issue(c, d, n, dv, sbyte, sack, sk, ok);
      if (!ok) return;
      bad_i = -1;
      bad_got = '0;
      bad_exp = '0;
      for (int i = 0; i < exp_trace.size(); i++) begin
         got = {scl_out, sda_out};
         if (got !== exp_trace[i] && bad_i < 0) begin
            bad_i = i;
            bad_got = got;
            bad_exp = exp_trace[i];
         end
         @(negedge clk);
      end
      tests++;
      if (bad_i >= 0) begin
         fails++;
         $display("FAIL %s_trace: cycle %0d scl/sda=%b expected %b", tag, bad_i, bad_got, bad_exp);
      end
      check({tag, "_final_lines"}, {30'b0, scl_out, sda_out}, {30'b0, exp_final});
      check({tag, "_busy_at_rsp"}, busy, 1);
      k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (busy) begin
         tests++;
         fails++;
         $display("FAIL %s_busy_timeout: busy=1 expected 0", tag);
      end
   endtask

   initial begin
      bit         ok;
      int         r;
      int         rc;
      logic [2:0] c;
      logic [2:0] bad_codes[4];
      bad_codes[0] = 3'd0;
      bad_codes[1] = 3'd5;
      bad_codes[2] = 3'd6;
      bad_codes[3] = 3'd7;

      repeat (3) @(negedge clk);
      check("reset_scl", scl_out, 1);
      check("reset_sda", sda_out, 1);
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_data", rsp_data, 0);
      check("reset_rsp_ack", rsp_ack, 0);
      check("reset_rsp_err", rsp_err, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_cmd(3'd1, 8'h00, 1'b0, 3, 8'h00, 1'b0, -1, "start_idle");
      run_cmd(3'd3, 8'hA5, 1'b0, 3, 8'h00, 1'b0, -1, "write_a5");
      run_cmd(3'd4, 8'h00, 1'b1, 3, 8'h3C, 1'b0, -1, "read_3c");
      run_cmd(3'd2, 8'h00, 1'b0, 1, 8'h00, 1'b0, -1, "stop");
      run_cmd(3'd3, 8'h5A, 1'b0, 3, 8'h00, 1'b0, -1, "write_idle");
      run_cmd(3'd4, 8'h00, 1'b0, 2, 8'hFF, 1'b0, -1, "read_idle");
      run_cmd(3'd2, 8'h00, 1'b0, 0, 8'h00, 1'b0, -1, "stop_idle");
      run_cmd(3'd5, 8'h00, 1'b0, 0, 8'h00, 1'b0, -1, "bad_idle");
      run_cmd(3'd1, 8'h00, 1'b0, 0, 8'h00, 1'b0, -1, "start_div0");
      run_cmd(3'd1, 8'h00, 1'b0, 2, 8'h00, 1'b0, -1, "restart");
      run_cmd(3'd7, 8'h00, 1'b0, 2, 8'h00, 1'b0, -1, "bad_held");
      run_cmd(3'd3, 8'hFF, 1'b0, 0, 8'h00, 1'b1, -1, "write_nak");
      run_cmd(3'd4, 8'h00, 1'b0, 0, 8'h81, 1'b0, -1, "read_ack");
      run_cmd(3'd2, 8'h00, 1'b0, 2, 8'h00, 1'b0, -1, "stop2");

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 1)      c = 3'd1;
         else if (r == 2) c = 3'd2;
         else if (r <= 5) c = 3'd3;
         else if (r <= 7) c = 3'd4;
         else if (r == 8) c = bad_codes[$urandom_range(0, 3)];
         else             c = 3'd2;
         run_cmd(c, W'($urandom), 1'($urandom), $urandom_range(0, 3), W'($urandom),
                 1'($urandom), -1, "rand");
      end

      if (!held) run_cmd(3'd1, 8'h00, 1'b0, 1, 8'h00, 1'b0, -1, "start_pre_stretch");
      run_cmd(3'd3, 8'hC3, 1'b0, 2, 8'h00, 1'b0, 3, "write_stretch");
      run_cmd(3'd4, 8'h00, 1'b0, 0, 8'h6D, 1'b0, 5, "read_stretch");

      // abandon a WRITE with reset part-way through
      if (!held) run_cmd(3'd1, 8'h00, 1'b0, 1, 8'h00, 1'b0, -1, "start_pre_reset");
      issue(3'd3, 8'h00, 1'b0, 1, 8'h00, 1'b0, -1, ok);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_scl", scl_out, 1);
      check("midrst_sda", sda_out, 1);
      check("midrst_cmd_ready", cmd_ready, 1);
      check("midrst_busy", busy, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      sb.delete();
      held = 1'b0;
      rc = rsp_cnt;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst_no_rsp", rsp_cnt, rc);
      run_cmd(3'd1, 8'h00, 1'b0, 1, 8'h00, 1'b0, -1, "start_after_rst");
      run_cmd(3'd2, 8'h00, 1'b0, 1, 8'h00, 1'b0, -1, "stop_after_rst");

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5_000_000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/i2c_master_engine.md
I2C_MASTER_ENGINE -- requirements
Module: i2c_master_engine

Interface
REQ-001 Parameter CTR_WIDTH, default 16: width of the phase counter and divisor.
REQ-002 Parameter DATA_WIDTH, default 8: bits per WRITE/READ transfer, MSB first.
REQ-003 Port clk  in  1: sole clock, rising edge.
REQ-004 Port rst  in  1: reset, asynchronous, active-high.
REQ-005 Port dbl_clock_divisor  in  CTR_WIDTH: phase length minus one, in clk cycles.
REQ-006 Ports cmd_valid in 1, cmd_ready out 1, cmd in 3, cmd_data in DATA_WIDTH, cmd_nack in 1: command handshake; cmd_nack is the ACK bit sent after READ.
REQ-007 Ports rsp_valid out 1, rsp_data out DATA_WIDTH, rsp_ack out 1, rsp_err out 1: one-cycle completion pulse with results.
REQ-008 Ports busy out 1, scl_out out 1, sda_out out 1 (1 = release line), scl_in in 1, sda_in in 1.

Function
REQ-009 Commands SHALL be START=1, STOP=2, WRITE=3, READ=4; other codes complete with rsp_err=1 and no bus activity.
REQ-010 A command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_ready SHALL be 1 only in IDLE and HELD states.
REQ-011 cmd, cmd_data, cmd_nack and dbl_clock_divisor SHALL be captured at acceptance; later changes have no effect until the next command.
REQ-012 Every phase SHALL last dbl_clock_divisor+1 cycles: counter runs 0..divisor, at counter==divisor the state advances and the counter returns to 0; divisor 0 gives 1-cycle phases.
REQ-013 States: IDLE, RS_LOW, START_SETUP, START_HOLD, BIT_LOW, BIT_HIGH, ACK_LOW, ACK_HIGH, STOP_LOW, STOP_SETUP, HELD.
REQ-014 START from IDLE: START_SETUP (scl=1, sda=1), START_HOLD (scl=1, sda=0), then HELD (scl=0, sda=0).
REQ-015 START from HELD (repeated start): RS_LOW (scl=0, sda=1), then as REQ-014.
REQ-016 WRITE: DATA_WIDTH x (BIT_LOW with sda=bit, BIT_HIGH scl=1), then ACK_LOW/ACK_HIGH with sda released; rsp_ack = sda_in sampled on the last cycle of ACK_HIGH (0 = ACK).
REQ-017 READ: sda released in bit phases; each bit sampled from sda_in on the last cycle of BIT_HIGH into rsp_data MSB first; ACK phases drive sda=cmd_nack; rsp_ack = cmd_nack.
REQ-018 STOP from HELD: STOP_LOW (scl=0, sda=0), STOP_SETUP (scl=1, sda=0), then IDLE with sda=1.
REQ-019 WRITE, READ or STOP in IDLE, and START is never refused; WRITE/READ/STOP in IDLE SHALL complete in the next cycle with rsp_err=1.
REQ-020 rsp_valid SHALL pulse for exactly one cycle on the cycle the final phase of the command ends; rsp_data/rsp_ack/rsp_err hold until the next pulse.
REQ-021 busy SHALL be 1 from acceptance until the rsp_valid cycle inclusive.

Reset
REQ-022 Reset SHALL force, asynchronously: state IDLE, counter 0, scl_out=1, sda_out=1, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_ack=0, rsp_err=0.
REQ-023 Reset mid-command SHALL abandon it with no rsp_valid; bus released immediately.

Configuration
REQ-024 With I2C_CLOCK_STRETCH_EN defined, the counter SHALL hold at 0 in any scl=1 phase while scl_in==0; phase length counts from scl_in high.
REQ-025 Without I2C_CLOCK_STRETCH_EN, scl_in SHALL be ignored; the port remains.

Structure
REQ-026 Package i2c_pkg SHALL hold command codes, state enum and phase constants.
REQ-027 Sub-module i2c_phase_timer SHALL hold the counter, divisor capture and stretch hold, emitting a phase_done strobe.

Verification
REQ-028 Reset then divisor=3, START in IDLE -> scl/sda 1/1 for 4 cycles, 1/0 for 4, then 0/0; rsp_valid at cycle 8, rsp_err=0.
REQ-029 After START, WRITE 0xA5 with sda_in=0 in ACK -> sda bits 1,0,1,0,0,1,0,1, 9 scl pulses, rsp_ack=0, total 72 cycles.
REQ-030 After START, READ with sda_in pattern 0x3C, cmd_nack=1 -> rsp_data=0x3C, sda=1 in ACK phase, rsp_ack=1.
REQ-031 WRITE in IDLE -> rsp_valid next cycle with rsp_err=1, scl/sda stay 1/1; repeated START from HELD -> RS_LOW then start sequence.
REQ-032 Stretch enabled, scl_in held 0 for 10 cycles in BIT_HIGH -> phase extended by 10 cycles; disabled -> no extension.
REQ-033 Assert rst mid-WRITE -> scl/sda 1/1 same cycle, no rsp_valid, cmd_ready=1.
